// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit accumulator processor: widths, opcodes,
// FSM state encodings and the control-word layout.
package proc_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned STATE_W   = 6;
  localparam int unsigned CTRL_W    = 20;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned MEM_DEPTH = 512;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_LDAC  = 4'd1;
  localparam logic [OP_W-1:0] OP_STAC  = 4'd2;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd4;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd5;
  localparam logic [OP_W-1:0] OP_MVR   = 4'd6;
  localparam logic [OP_W-1:0] OP_JMP   = 4'd7;
  localparam logic [OP_W-1:0] OP_JMPZ  = 4'd8;
  localparam logic [OP_W-1:0] OP_LDI   = 4'd9;
  localparam logic [OP_W-1:0] OP_INC   = 4'd10;
  localparam logic [OP_W-1:0] OP_LDAR  = 4'd11;
  localparam logic [OP_W-1:0] OP_LDIND = 4'd12;
  localparam logic [OP_W-1:0] OP_STIND = 4'd13;
  localparam logic [OP_W-1:0] OP_MVRAC = 4'd14;
  localparam logic [OP_W-1:0] OP_END   = 4'd15;

  localparam logic [STATE_W-1:0] S_IDLE   = 6'd0;
  localparam logic [STATE_W-1:0] S_FETCH1 = 6'd1;
  localparam logic [STATE_W-1:0] S_FETCH2 = 6'd2;
  localparam logic [STATE_W-1:0] S_DECODE = 6'd3;
  localparam logic [STATE_W-1:0] S_EXEC   = 6'd4;
  localparam logic [STATE_W-1:0] S_MEMRD  = 6'd5;
  localparam logic [STATE_W-1:0] S_MEMWB  = 6'd6;
  localparam logic [STATE_W-1:0] S_HALT   = 6'd7;

  // Field order makes pc_inc land on bit 0 and z_load on bit 13.
  typedef struct packed {
    logic            z_load;
    logic [OP_W-1:0] alu_op;
    logic            dram_re;
    logic            iram_re;
    logic            dram_we;
    logic            r_load;
    logic            ac_load;
    logic            ar_load;
    logic            ir_load;
    logic            pc_load;
    logic            pc_inc;
  } ctrl_t;

endpackage

// File: rtl/proc_ram.sv
// 512x16 simple dual-port RAM, synchronous read with one cycle of latency.
module proc_ram
  import proc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Array is deliberately not reset so preloaded contents survive reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-edge write/read of one address returns the old word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/proc_top_control.sv
// Single-core accumulator processor: control FSM, register file, ALU and the
// IRAM/DRAM pair with host load and readout ports.
module proc_top_control
  import proc_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               start_2,
  input  logic               start_3,
  input  logic               start_4,
  input  logic [ADDR_W-1:0]  addr_ext,
  input  logic               iram_write_ext,
  input  logic               dram_write_ext,
  input  logic               read_en_ext,
  input  logic [DATA_W-1:0]  Data_in_ins,
  input  logic [DATA_W-1:0]  Data_in_dram,
  output logic [DATA_W-1:0]  dram_in,
  output logic [DATA_W-1:0]  iram_in,
  output logic [DATA_W-1:0]  dram_out,
  output logic [DATA_W-1:0]  pc_out,
  output logic [DATA_W-1:0]  ar_out,
  output logic [CTRL_W-1:0]  control_out,
  output logic [STATE_W-1:0] state,
  output logic [DATA_W-1:0]  data_in_pc,
  output logic [DATA_W-1:0]  alu_in_1,
  output logic [DATA_W-1:0]  alu_in_2,
  output logic [DATA_W-1:0]  alu_out,
  output logic               write_en,
  output logic [1:0]         read_en
);

  logic [ADDR_W-1:0]  pc;
  logic [OP_W-1:0]    ir_op;
  logic [ADDR_W-1:0]  ir_arg;
  logic [DATA_W-1:0]  ar, ac, r;
  logic               z, run_q;
  logic [STATE_W-1:0] state_nxt;
  ctrl_t              ctrl;

  logic mode_iload, mode_dload, mode_rdout, run, enter_run;
  assign mode_iload = start_2;
  assign mode_dload = !start_2 && start_3;
  assign mode_rdout = !start_2 && !start_3 && start_4;
  assign run        = !start_2 && !start_3 && !start_4 && start;
  assign enter_run  = (state == S_IDLE) && (state_nxt == S_FETCH1);

  // Indirect memory ops address through AR, direct ones through the operand.
  logic [ADDR_W-1:0] mem_addr;
  assign mem_addr = (ir_op == OP_LDIND || ir_op == OP_STIND) ? ar[ADDR_W-1:0] : ir_arg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    if (!run) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (!run_q) state_nxt = S_FETCH1;
        S_FETCH1: begin
          ctrl.iram_re = 1'b1;
          state_nxt    = S_FETCH2;
        end
        S_FETCH2: begin
          ctrl.ir_load = 1'b1;
          ctrl.pc_inc  = 1'b1;
          state_nxt    = S_DECODE;
        end
        S_DECODE: begin
          case (ir_op)
            OP_LDAC, OP_LDIND: state_nxt = S_MEMRD;
            OP_END:            state_nxt = S_HALT;
            default:           state_nxt = S_EXEC;
          endcase
        end
        S_EXEC: begin
          ctrl.alu_op = ir_op;
          state_nxt   = S_FETCH1;
          case (ir_op)
            OP_ADD, OP_SUB, OP_MUL, OP_LDI, OP_INC, OP_MVRAC: begin
              ctrl.ac_load = 1'b1;
              ctrl.z_load  = 1'b1;
            end
            OP_STAC, OP_STIND: ctrl.dram_we = 1'b1;
            OP_MVR:            ctrl.r_load  = 1'b1;
            OP_LDAR:           ctrl.ar_load = 1'b1;
            OP_JMP:            ctrl.pc_load = 1'b1;
            OP_JMPZ:           ctrl.pc_load = z;
            default:           ctrl.alu_op  = ir_op;
          endcase
        end
        S_MEMRD: begin
          ctrl.dram_re = 1'b1;
          state_nxt    = S_MEMWB;
        end
        S_MEMWB: begin
          ctrl.ac_load = 1'b1;
          ctrl.z_load  = 1'b1;
          state_nxt    = S_FETCH1;
        end
        S_HALT:   state_nxt = S_HALT;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // INC and LDI reuse the adder/pass-through by steering the second operand.
  always_comb begin
    alu_in_1 = ac;
    alu_in_2 = r;
    if (ctrl.alu_op == OP_INC)      alu_in_2 = 16'd1;
    else if (ctrl.alu_op == OP_LDI) alu_in_2 = {7'd0, ir_arg};
    case (ctrl.alu_op)
      OP_ADD, OP_INC:   alu_out = alu_in_1 + alu_in_2;
      OP_SUB:           alu_out = alu_in_1 - alu_in_2;
      OP_MUL:           alu_out = alu_in_1 * alu_in_2;
      OP_LDI, OP_MVRAC: alu_out = alu_in_2;
      default:          alu_out = alu_in_1;
    endcase
  end

  logic [DATA_W-1:0] ac_nxt;
  assign ac_nxt = (state == S_MEMWB) ? dram_in : alu_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= 9'd1;
      ir_op  <= '0;
      ir_arg <= '0;
      ar     <= '0;
      ac     <= '0;
      r      <= '0;
      z      <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      run_q <= run;
      if (enter_run)         pc <= 9'd1;
      else if (ctrl.pc_load) pc <= ir_arg;
      else if (ctrl.pc_inc)  pc <= pc + 9'd1;
      if (ctrl.ir_load) begin
        ir_op  <= iram_in[15:12];
        ir_arg <= iram_in[ADDR_W-1:0];
      end
      if (ctrl.ar_load) ar <= ac;
      if (ctrl.r_load)  r  <= ac;
      if (ctrl.ac_load) ac <= ac_nxt;
      if (ctrl.z_load)  z  <= (ac_nxt == '0);
    end
  end

  proc_ram u_iram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (mode_iload && iram_write_ext),
    .waddr   (addr_ext),
    .wdata   (Data_in_ins),
    .re      (ctrl.iram_re),
    .raddr   (pc),
    .rdata   (iram_in)
  );

  proc_ram u_dram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (mode_dload ? dram_write_ext : ctrl.dram_we),
    .waddr   (mode_dload ? addr_ext : mem_addr),
    .wdata   (mode_dload ? Data_in_dram : ac),
    .re      (mode_rdout ? read_en_ext : ctrl.dram_re),
    .raddr   (mode_rdout ? addr_ext : mem_addr),
    .rdata   (dram_in)
  );

  assign dram_out    = ac;
  assign pc_out      = {7'd0, pc};
  assign ar_out      = ar;
  assign control_out = {{(CTRL_W - $bits(ctrl_t)){1'b0}}, ctrl};
  assign data_in_pc  = {7'd0, (ctrl.pc_load ? ir_arg : pc + 9'd1)};
  assign write_en    = ctrl.dram_we;
  assign read_en     = {ctrl.dram_re, ctrl.iram_re};

endmodule

// File: tb/tb_proc_top_control.sv
// Self-checking bench for proc_top_control against an instruction-level model.
module tb_proc_top_control;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, start_2, start_3, start_4;
  logic [8:0]  addr_ext;
  logic        iram_write_ext, dram_write_ext, read_en_ext;
  logic [15:0] Data_in_ins, Data_in_dram;
  logic [15:0] dram_in, iram_in, dram_out, pc_out, ar_out;
  logic [19:0] control_out;
  logic [5:0]  state;
  logic [15:0] data_in_pc, alu_in_1, alu_in_2, alu_out;
  logic        write_en;
  logic [1:0]  read_en;

  always #5 clock = ~clock;

  proc_top_control dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_2(start_2),
    .start_3(start_3), .start_4(start_4), .addr_ext(addr_ext),
    .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
    .read_en_ext(read_en_ext), .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram),
    .dram_in(dram_in), .iram_in(iram_in), .dram_out(dram_out), .pc_out(pc_out),
    .ar_out(ar_out), .control_out(control_out), .state(state), .data_in_pc(data_in_pc),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_out(alu_out),
    .write_en(write_en), .read_en(read_en)
  );

  int n_pass = 0;
  int n_total = 0;

  // Instruction-level reference: memory images plus architectural registers.
  logic [15:0] miram [512];
  logic [15:0] mdram [512];
  logic [15:0] m_ac, m_r, m_ar;
  logic        m_z;
  int          m_pc_end, m_cycles;
  int          exp_trace[$];
  int          dut_trace[$];
  logic [15:0] dut_fetch[$];
  int          dut_cycles;
  bit          dut_halted;

  task automatic model_reset();
    m_ac = 0; m_r = 0; m_ar = 0; m_z = 0;
  endtask

  // Executes from address 1 until END; cycles include the IDLE->FETCH1 edge.
  task automatic model_run();
    int pc;
    logic [15:0] ins;
    logic [8:0] a;
    exp_trace.delete();
    pc = 1;
    m_cycles = 1;
    for (int s = 0; s < 4000; s++) begin
      ins = miram[pc];
      exp_trace.push_back(pc);
      pc = (pc + 1) % 512;
      a = ins[8:0];
      if (ins[15:12] == 4'd15) begin
        m_cycles += 3;
        break;
      end
      m_cycles += (ins[15:12] == 4'd1 || ins[15:12] == 4'd12) ? 5 : 4;
      case (ins[15:12])
        4'd1:  begin m_ac = mdram[a]; m_z = (m_ac == 0); end
        4'd2:  mdram[a] = m_ac;
        4'd3:  begin m_ac = 16'((int'(m_ac) + int'(m_r)) % 65536); m_z = (m_ac == 0); end
        4'd4:  begin m_ac = 16'((int'(m_ac) - int'(m_r) + 65536) % 65536); m_z = (m_ac == 0); end
        4'd5:  begin m_ac = 16'((longint'(m_ac) * longint'(m_r)) % 65536); m_z = (m_ac == 0); end
        4'd6:  m_r = m_ac;
        4'd7:  pc = int'(a);
        4'd8:  if (m_z) pc = int'(a);
        4'd9:  begin m_ac = 16'(int'(a)); m_z = (m_ac == 0); end
        4'd10: begin m_ac = 16'((int'(m_ac) + 1) % 65536); m_z = (m_ac == 0); end
        4'd11: m_ar = m_ac;
        4'd12: begin m_ac = mdram[m_ar[8:0]]; m_z = (m_ac == 0); end
        4'd13: mdram[m_ar[8:0]] = m_ac;
        4'd14: begin m_ac = m_r; m_z = (m_ac == 0); end
        default: ;
      endcase
    end
    m_pc_end = pc;
  endtask

  task automatic load_iram(input int base, input logic [15:0] w[$]);
    @(negedge clock);
    start_2 = 1; iram_write_ext = 1;
    foreach (w[i]) begin
      addr_ext = 9'(base + i); Data_in_ins = w[i]; miram[base + i] = w[i];
      @(negedge clock);
    end
    iram_write_ext = 0; start_2 = 0;
  endtask

  task automatic load_dram(input int addr, input logic [15:0] d);
    @(negedge clock);
    start_3 = 1; dram_write_ext = 1; addr_ext = 9'(addr); Data_in_dram = d;
    mdram[addr] = d;
    @(negedge clock);
    dram_write_ext = 0; start_3 = 0;
  endtask

  task automatic read_dram(input int addr, output logic [15:0] d);
    @(negedge clock);
    start_4 = 1; read_en_ext = 1; addr_ext = 9'(addr);
    @(negedge clock);
    d = dram_in;
    read_en_ext = 0; start_4 = 0;
  endtask

  task automatic run_prog();
    @(negedge clock);
    start = 1;
    dut_cycles = 0; dut_halted = 0;
    dut_trace.delete(); dut_fetch.delete();
    while (!dut_halted && dut_cycles < 4000) begin
      @(posedge clock); #1;
      dut_cycles++;
      if (state == 6'd1) dut_trace.push_back(int'(pc_out));
      if (state == 6'd2) dut_fetch.push_back(iram_in);
      if (state == 6'd7) dut_halted = 1;
    end
    @(negedge clock);
    start = 0;
    @(negedge clock);
  endtask

  task automatic check_run(input string tag);
    bit same;
    n_total++;
    if (!dut_halted) $display("FAIL %s halt: no HALT within %0d cycles", tag, dut_cycles);
    else n_pass++;
    n_total++;
    if (dut_cycles !== m_cycles) $display("FAIL %s cycles: got %0d want %0d", tag, dut_cycles, m_cycles);
    else n_pass++;
    same = (dut_trace.size() == exp_trace.size());
    if (same) foreach (exp_trace[i]) if (dut_trace[i] != exp_trace[i]) same = 0;
    n_total++;
    if (!same) $display("FAIL %s pc_trace: got %0d fetches want %0d", tag, dut_trace.size(), exp_trace.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(negedge clock);
    n_total++;
    if (state !== 6'd0 || pc_out !== 16'd1) $display("FAIL reset_state: state=%0d pc=%0d want 0/1", state, pc_out);
    else n_pass++;
    n_total++;
    if (control_out !== 20'd0 || read_en !== 2'b00 || write_en !== 1'b0 || dram_out !== 16'd0 || ar_out !== 16'd0)
      $display("FAIL reset_outputs: ctrl=%h re=%b we=%b ac=%h ar=%h want 0", control_out, read_en, write_en, dram_out, ar_out);
    else n_pass++;
    reset_n = 1;
    model_reset();
  endtask

  task automatic fill_dram();
    @(negedge clock);
    start_3 = 1; dram_write_ext = 1;
    for (int a = 0; a < 512; a++) begin
      addr_ext = 9'(a); Data_in_dram = 16'($urandom); mdram[a] = Data_in_dram;
      @(negedge clock);
    end
    dram_write_ext = 0; start_3 = 0;
  endtask

  task automatic test_iram_load();
    logic [15:0] p[$];
    bit same;
    p = '{16'h9005, 16'h6000, 16'hF000};
    load_iram(1, p);
    model_run();
    run_prog();
    check_run("iram_load");
    same = (dut_fetch.size() == 3);
    if (same) foreach (p[i]) if (dut_fetch[i] !== p[i]) same = 0;
    n_total++;
    if (!same) $display("FAIL iram_readback: got %0d words, first %h want 9005 6000 f000", dut_fetch.size(),
                        dut_fetch.size() > 0 ? dut_fetch[0] : 16'hxxxx);
    else n_pass++;
    n_total++;
    if (dram_out !== 16'd5) $display("FAIL iram_prog_ac: got %h want 0005", dram_out);
    else n_pass++;
  endtask

  task automatic test_const_store();
    logic [15:0] p[$];
    logic [15:0] d;
    p = '{16'h9005, 16'h6000, 16'h9003, 16'h5000, 16'h200A, 16'hF000};
    load_iram(1, p);
    load_dram(10, 16'hAAAA);
    model_run();
    run_prog();
    check_run("const_store");
    n_total++;
    if (dut_cycles > 27) $display("FAIL const_halt_time: got %0d cycles want <= 27", dut_cycles);
    else n_pass++;
    read_dram(10, d);
    n_total++;
    if (d !== 16'd15) $display("FAIL const_dram10: got %h want 000f", d);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] p[$];
    logic [15:0] d;
    p = '{16'h1001, 16'hA000, 16'h2002, 16'h8006, 16'hF000, 16'h9007, 16'h2003, 16'hF000};
    load_iram(1, p);
    load_dram(1, 16'hFFFF);
    load_dram(2, 16'h1234);
    load_dram(3, 16'h1234);
    model_run();
    run_prog();
    check_run("wrap");
    read_dram(2, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL wrap_dram2: got %h want 0000", d);
    else n_pass++;
    read_dram(3, d);
    n_total++;
    if (d !== 16'h0007) $display("FAIL wrap_zflag_jump: dram3=%h want 0007", d);
    else n_pass++;
  endtask

  task automatic test_loop();
    logic [15:0] p[$];
    logic [15:0] d;
    int want[$];
    bit same;
    p = '{16'h9001, 16'h6000, 16'h9003, 16'h4000, 16'h8007, 16'h7004, 16'h2014, 16'hF000};
    want = '{1, 2, 3, 4, 5, 6, 4, 5, 6, 4, 5, 7, 8};
    load_iram(1, p);
    load_dram(20, 16'hBEEF);
    model_run();
    run_prog();
    check_run("loop");
    same = (dut_trace.size() == want.size());
    if (same) foreach (want[i]) if (dut_trace[i] != want[i]) same = 0;
    n_total++;
    if (!same) $display("FAIL loop_jump_targets: got %0d fetches want %0d", dut_trace.size(), want.size());
    else n_pass++;
    read_dram(20, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL loop_dram20: got %h want 0000", d);
    else n_pass++;
  endtask

  task automatic test_readout();
    load_dram(10, 16'($urandom));
    load_dram(11, 16'($urandom));
    load_dram(12, 16'($urandom));
    @(negedge clock);
    start_4 = 1; read_en_ext = 1;
    for (int a = 10; a <= 12; a++) begin
      addr_ext = 9'(a);
      @(negedge clock);
      n_total++;
      if (dram_in !== mdram[a]) $display("FAIL readout_%0d: got %h want %h", a, dram_in, mdram[a]);
      else n_pass++;
    end
    read_en_ext = 0; start_4 = 0;
  endtask

  task automatic test_random_programs();
    int ops[13];
    logic [15:0] p[$];
    int len, bad;
    ops = '{0, 1, 2, 3, 4, 5, 6, 9, 10, 11, 12, 13, 14};
    for (int k = 0; k < 8; k++) begin
      p.delete();
      len = $urandom_range(4, 14);
      for (int i = 0; i < len; i++)
        p.push_back({4'(ops[$urandom_range(0, 12)]), 3'($urandom), 9'($urandom)});
      p.push_back(16'hF000);
      load_iram(1, p);
      model_run();
      run_prog();
      check_run($sformatf("rand%0d", k));
      n_total++;
      if (dram_out !== m_ac || ar_out !== m_ar || pc_out !== 16'(m_pc_end))
        $display("FAIL rand%0d_regs: ac=%h ar=%h pc=%0d want %h %h %0d", k, dram_out, ar_out, pc_out, m_ac, m_ar, m_pc_end);
      else n_pass++;
      bad = -1;
      @(negedge clock);
      start_4 = 1; read_en_ext = 1;
      for (int a = 0; a < 512; a++) begin
        addr_ext = 9'(a);
        @(negedge clock);
        if (bad < 0 && dram_in !== mdram[a]) bad = a;
      end
      read_en_ext = 0; start_4 = 0;
      n_total++;
      if (bad >= 0) $display("FAIL rand%0d_dram: addr %0d got %h want %h", k, bad, dram_in, mdram[bad]);
      else n_pass++;
    end
  endtask

  task automatic test_stop_midrun();
    @(negedge clock);
    start = 1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    start = 0;
    @(posedge clock); #1;
    n_total++;
    if (state !== 6'd0) $display("FAIL stop_midrun_state: got %0d want 0", state);
    else n_pass++;
    n_total++;
    if (control_out !== 20'd0 || write_en !== 1'b0) $display("FAIL stop_midrun_ctrl: ctrl=%h we=%b want 0", control_out, write_en);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    logic [15:0] p[$];
    logic [15:0] d;
    int waited;
    bit same;
    p = '{16'h9005, 16'h6000, 16'h9003, 16'h5000, 16'h200A, 16'hF000};
    load_iram(1, p);
    load_dram(10, 16'h1234);
    @(negedge clock);
    start = 1;
    waited = 0;
    do begin
      @(posedge clock); #1;
      waited++;
    end while (state !== 6'd4 && waited < 40);
    n_total++;
    if (state !== 6'd4) $display("FAIL reset_mid_reach_exec: state=%0d want 4", state);
    else n_pass++;
    reset_n = 0;
    #1;
    n_total++;
    if (state !== 6'd0 || pc_out !== 16'd1) $display("FAIL reset_mid_state: state=%0d pc=%0d want 0/1", state, pc_out);
    else n_pass++;
    start = 0;
    @(negedge clock);
    reset_n = 1;
    model_reset();
    model_run();
    run_prog();
    check_run("reset_mid");
    same = (dut_fetch.size() == p.size());
    if (same) foreach (p[i]) if (dut_fetch[i] !== p[i]) same = 0;
    n_total++;
    if (!same) $display("FAIL reset_mid_iram_intact: fetched %0d words want %0d", dut_fetch.size(), p.size());
    else n_pass++;
    read_dram(10, d);
    n_total++;
    if (d !== 16'd15) $display("FAIL reset_mid_dram10: got %h want 000f", d);
    else n_pass++;
  endtask

  initial begin
    start = 0; start_2 = 0; start_3 = 0; start_4 = 0;
    addr_ext = 0; iram_write_ext = 0; dram_write_ext = 0; read_en_ext = 0;
    Data_in_ins = 0; Data_in_dram = 0;
    test_reset();
    fill_dram();
    test_iram_load();
    test_const_store();
    test_wrap();
    test_loop();
    test_readout();
    test_random_programs();
    test_stop_midrun();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
